// File: rtl/cfg_chain_loader.sv
// Serializes a valid/ready word stream MSB-first into a configuration scan chain.
// Define CFG_READBACK_EN to check chain_tail during the load and report errors on err.
module cfg_chain_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int DATA_W    = 8
) (
    input  logic              CK,
    input  logic              RSTN,
    input  logic              start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              chain_rst,
    output logic              chain_se,
    output logic              chain_shift,
    output logic              chain_head,
    input  logic              chain_tail,
    output logic              busy,
    output logic              cfg_done,
    output logic              err
);

    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam int BUF_CNT_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BUF_CNT_W-1:0] BUF_FULL = BUF_CNT_W'(DATA_W);
    localparam logic [BUF_CNT_W-1:0] BUF_ONE  = BUF_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DONE
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_W-1:0]     word_buf;
    logic [BUF_CNT_W-1:0]  buf_cnt;
    logic                  clr_cnt;

    logic buf_empty;
    logic last_in_buf;
    logic accept;
    logic final_shift;
    logic start_ok;

    // NOTE: every signal written here gets a value on every path, so no latches are inferred.
    always_comb begin
        buf_empty   = (buf_cnt == '0);
        last_in_buf = (buf_cnt == BUF_ONE);
        chain_shift = (state == SHIFT) && !buf_empty;
        chain_head  = word_buf[DATA_W-1];
        // Refill while the last buffered bit leaves, unless that bit completes the chain.
        s_ready     = (state == SHIFT) && (buf_empty || (last_in_buf && (bit_cnt < LAST_BIT)));
        accept      = s_ready && s_valid;
        final_shift = chain_shift && (bit_cnt == LAST_BIT);
        start_ok    = start && ((state == IDLE) || (state == DONE));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: the word buffer is a single small register, so it is reset with the rest of the state.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            chain_rst <= 1'b1;
            chain_se  <= 1'b0;
            busy      <= 1'b0;
            cfg_done  <= 1'b0;
            bit_cnt   <= '0;
            word_buf  <= '0;
            buf_cnt   <= '0;
            clr_cnt   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    chain_rst <= 1'b0;
                    if (start_ok) begin
                        state     <= CLEAR;
                        chain_rst <= 1'b1;
                        busy      <= 1'b1;
                        cfg_done  <= 1'b0;
                        clr_cnt   <= 1'b0;
                        bit_cnt   <= '0;
                        word_buf  <= '0;
                        buf_cnt   <= '0;
                    end
                end

                CLEAR: begin
                    clr_cnt <= 1'b1;
                    if (clr_cnt) begin
                        state     <= SHIFT;
                        chain_rst <= 1'b0;
                        chain_se  <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (chain_shift) begin
                        word_buf <= word_buf << 1;
                        buf_cnt  <= buf_cnt - BUF_ONE;
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                    end
                    if (accept) begin
                        word_buf <= s_data;
                        buf_cnt  <= BUF_FULL;
                    end
                    // Bits still buffered at completion are padding and are dropped.
                    if (final_shift) begin
                        state    <= DONE;
                        chain_se <= 1'b0;
                        busy     <= 1'b0;
                        cfg_done <= 1'b1;
                        word_buf <= '0;
                        buf_cnt  <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CFG_READBACK_EN
    // The chain was cleared before shifting, so any 1 seen at the tail during a load is corruption.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            err <= 1'b0;
        end else if (start_ok) begin
            err <= 1'b0;
        end else if (chain_shift && chain_tail) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_tail;
    assign unused_tail = chain_tail;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: stream-level reference model plus a behavioural scan chain.
module tb_cfg_chain_loader;

    localparam int CHAIN_LEN = 20;
    localparam int DATA_W    = 8;
    localparam int N_WORDS   = (CHAIN_LEN + DATA_W - 1) / DATA_W;
`ifdef CFG_READBACK_EN
    localparam logic READBACK = 1'b1;
`else
    localparam logic READBACK = 1'b0;
`endif

    logic              CK = 1'b0;
    logic              RSTN = 1'b0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready, chain_rst, chain_se, chain_shift, chain_head;
    logic              chain_tail, busy, cfg_done, err;

    logic [CHAIN_LEN-1:0] chain = '0;
    logic                 force_tail = 1'b0;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [DATA_W-1:0] words[$];
    logic              exp_bits[$];
    logic              heads[$];

    cfg_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .DATA_W(DATA_W)) dut (
        .CK(CK), .RSTN(RSTN), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .chain_rst(chain_rst), .chain_se(chain_se),
        .chain_shift(chain_shift), .chain_head(chain_head), .chain_tail(chain_tail),
        .busy(busy), .cfg_done(cfg_done), .err(err)
    );

    always #5 CK = ~CK;

    // Fabric side: a plain shift register of scan flops with active-high clear.
    always @(posedge CK) begin
        if (chain_rst)        chain <= '0;
        else if (chain_shift) chain <= {chain[CHAIN_LEN-2:0], chain_head};
    end
    assign chain_tail = force_tail | chain[CHAIN_LEN-1];

    // Expected serial stream: words MSB-first, concatenated, truncated to the chain length.
    task automatic build_expected();
        logic [DATA_W-1:0] w;
        exp_bits.delete();
        for (int i = 0; i < CHAIN_LEN; i++) begin
            w = words[i / DATA_W];
            exp_bits.push_back(w[DATA_W-1 - (i % DATA_W)]);
        end
    endtask

    // gap < 0 selects random gaps of 0..6 cycles after each accepted word.
    task automatic run_load(input string name, input int gap, input bit mid_start,
                            input int force_at, input int abort_at);
        int   acc_bits = 0, shifted = 0, sent = 0, gap_left = 0, cyc = 0;
        int   proto_errs = 0, first_cyc = -1, last_cyc = -1, pending;
        bit   hs = 0, mid_done = 0, aborted = 0;
        logic err_exp = 1'b0;
        logic exp_sh, exp_rdy;
        logic [6:0] got_v, exp_v, bad_got = '0, bad_exp = '0;
        int   mis;

        build_expected();
        heads.delete();

        @(negedge CK); start = 1'b1;
        @(negedge CK); start = 1'b0;
        checks_total++;
        if ({chain_rst, busy, chain_se, s_ready, chain_shift, cfg_done, err} !== 7'b1100000)
            $display("FAIL %s clear1: got %b want 1100000", name,
                     {chain_rst, busy, chain_se, s_ready, chain_shift, cfg_done, err});
        else checks_passed++;
        @(negedge CK);
        checks_total++;
        if ({chain_rst, busy, chain_se, s_ready, chain_shift, cfg_done, err} !== 7'b1100000)
            $display("FAIL %s clear2: got %b want 1100000", name,
                     {chain_rst, busy, chain_se, s_ready, chain_shift, cfg_done, err});
        else checks_passed++;
        @(negedge CK);

        while (shifted < CHAIN_LEN && cyc < 400) begin
            if (hs) begin
                acc_bits += DATA_W;
                sent++;
                gap_left = (gap < 0) ? int'($urandom_range(0, 6)) : gap;
            end
            if (force_tail) err_exp = READBACK;
            pending = acc_bits - shifted;
            exp_sh  = (pending > 0);
            exp_rdy = (pending == 0) || (pending == 1 && shifted + 1 < CHAIN_LEN);
            got_v = {chain_rst, chain_se, busy, cfg_done, err, s_ready, chain_shift};
            exp_v = {1'b0, 1'b1, 1'b1, 1'b0, err_exp, exp_rdy, exp_sh};
            if (got_v !== exp_v) begin
                if (proto_errs == 0) begin bad_got = got_v; bad_exp = exp_v; end
                proto_errs++;
            end
            force_tail = 1'b0;
            if (chain_shift === 1'b1) begin
                heads.push_back(chain_head);
                shifted++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (force_at > 0 && shifted == force_at) force_tail = 1'b1;
            end
            if (abort_at > 0 && shifted == abort_at) begin aborted = 1; break; end
            start = (mid_start && !mid_done && shifted == 7);
            if (start) mid_done = 1;
            if (gap_left > 0) begin
                s_valid = 1'b0;
                gap_left--;
            end else if (sent < words.size()) begin
                s_valid = 1'b1;
                s_data  = words[sent];
            end else begin
                s_valid = 1'b0;
            end
            hs = s_valid && s_ready;
            @(negedge CK);
            cyc++;
        end
        start = 1'b0;

        checks_total++;
        if (proto_errs != 0)
            $display("FAIL %s per_cycle: %0d bad cycles, first got %b want %b", name,
                     proto_errs, bad_got, bad_exp);
        else checks_passed++;

        if (aborted) begin
            #2 RSTN = 1'b0;
            #1;
            checks_total++;
            if ({chain_rst, chain_se, busy, cfg_done, err, s_ready, chain_shift, chain_head} !== 8'b10000000)
                $display("FAIL %s async_reset: got %b want 10000000", name,
                         {chain_rst, chain_se, busy, cfg_done, err, s_ready, chain_shift, chain_head});
            else checks_passed++;
            @(negedge CK);
            #2 RSTN = 1'b1;
            s_valid = 1'b1;
            s_data  = 8'hFF;
            mis = 0;
            repeat (6) begin
                @(negedge CK);
                if ({chain_rst, chain_se, busy, cfg_done, s_ready, chain_shift} !== 6'b0) mis++;
            end
            s_valid = 1'b0;
            checks_total++;
            if (mis != 0) $display("FAIL %s stays_idle: %0d bad cycles, want 0", name, mis);
            else checks_passed++;
            return;
        end

        checks_total++;
        if (cyc >= 400) $display("FAIL %s timeout: shifts %0d want %0d", name, shifted, CHAIN_LEN);
        else checks_passed++;

        checks_total++;
        if ({cfg_done, chain_se, busy, s_ready, chain_shift, chain_rst, err} !== {6'b100000, err_exp})
            $display("FAIL %s done_state: got %b want %b", name,
                     {cfg_done, chain_se, busy, s_ready, chain_shift, chain_rst, err}, {6'b100000, err_exp});
        else checks_passed++;

        mis = 0;
        for (int i = 0; i < CHAIN_LEN; i++)
            if (i >= heads.size() || heads[i] !== exp_bits[i]) mis++;
        checks_total++;
        if (mis != 0 || heads.size() != CHAIN_LEN)
            $display("FAIL %s head_seq: %0d wrong bits, %0d shifts want %0d", name, mis, heads.size(), CHAIN_LEN);
        else checks_passed++;

        mis = 0;
        for (int i = 0; i < CHAIN_LEN; i++)
            if (chain[CHAIN_LEN-1-i] !== exp_bits[i]) mis++;
        checks_total++;
        if (mis != 0) $display("FAIL %s chain_contents: %0d wrong flops want 0", name, mis);
        else checks_passed++;

        checks_total++;
        if (sent != N_WORDS) $display("FAIL %s words_taken: got %0d want %0d", name, sent, N_WORDS);
        else checks_passed++;

        if (gap == 0) begin
            checks_total++;
            if (last_cyc - first_cyc != CHAIN_LEN - 1)
                $display("FAIL %s contiguous: span %0d want %0d", name, last_cyc - first_cyc + 1, CHAIN_LEN);
            else checks_passed++;
        end
    endtask

    task automatic set_plan_words();
        words.delete();
        words.push_back(8'hA5);
        words.push_back(8'h3C);
        words.push_back(8'hF0);
        words.push_back(8'h81);
    endtask

    task automatic set_random_words();
        words.delete();
        for (int i = 0; i <= N_WORDS; i++) words.push_back(DATA_W'($urandom));
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        @(negedge CK);
        @(negedge CK);
        checks_total++;
        if ({chain_rst, chain_se, busy, cfg_done, err, s_ready, chain_shift, chain_head} !== 8'b10000000)
            $display("FAIL reset_values: got %b want 10000000",
                     {chain_rst, chain_se, busy, cfg_done, err, s_ready, chain_shift, chain_head});
        else checks_passed++;
        #2 RSTN = 1'b1;
        @(negedge CK);
        checks_total++;
        if ({chain_rst, chain_se, busy, cfg_done, s_ready} !== 5'b0)
            $display("FAIL reset_release: got %b want 00000", {chain_rst, chain_se, busy, cfg_done, s_ready});
        else checks_passed++;
    endtask

    task automatic test_back_to_back();
        set_plan_words();
        run_load("back_to_back", 0, 1'b0, 0, 0);
    endtask

    task automatic test_gaps();
        set_plan_words();
        run_load("gaps", 3, 1'b0, 0, 0);
    endtask

    task automatic test_mid_start();
        set_plan_words();
        run_load("mid_start", 0, 1'b1, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            set_random_words();
            run_load("random", (n == 0) ? 0 : -1, 1'b0, 0, 0);
        end
    endtask

    task automatic test_readback();
        set_plan_words();
        run_load("readback", 0, 1'b0, 5, 0);
        set_random_words();
        run_load("after_readback", -1, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid_shift();
        set_plan_words();
        run_load("reset_mid_shift", 0, 1'b0, 0, 10);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_mid_start();
        test_random();
        test_readback();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
